// File: rtl/conv_out_drain_if.sv
// Output beat stream of conv_out_drain: valid/ready beats with set and frame markers.
interface conv_out_drain_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4
);
  logic [LANES-1:0][DATA_WIDTH-1:0] m_data;
  logic                             m_valid;
  logic                             m_ready;
  logic                             m_last;
  logic                             m_frame_last;

  modport master (
    output m_data, m_valid, m_last, m_frame_last,
    input  m_ready
  );

  modport slave (
    input  m_data, m_valid, m_last, m_frame_last,
    output m_ready
  );
endinterface

// File: rtl/conv_out_drain.sv
// Result drain: buffers full-width result sets and serializes them LANES words per beat.
// Optional build macro CONV_DRAIN_RELU_EN zeroes negative lanes on the output path only.
module conv_out_drain #(
  parameter int DATA_WIDTH     = 32,
  parameter int DATA_OF_SET    = 128,
  parameter int OUT_NUM_OF_SET = 3,
  parameter int LANES          = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] i_dout,
  input  logic                                   i_dout_valid,
  conv_out_drain_if.master                       m_if,
  output logic [$clog2(OUT_NUM_OF_SET+1)-1:0]    o_level,
  output logic                                   o_overflow,
  input  logic                                   i_ovf_clr
);

  localparam int BEATS = DATA_OF_SET / LANES;
  localparam int CW    = $clog2(OUT_NUM_OF_SET + 1);
  localparam int PW    = (OUT_NUM_OF_SET > 1) ? $clog2(OUT_NUM_OF_SET) : 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int EW    = (DATA_OF_SET > 1) ? $clog2(DATA_OF_SET) : 1;

  localparam logic [PW-1:0] LAST_PTR  = PW'(OUT_NUM_OF_SET - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(OUT_NUM_OF_SET);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic [0:0]                             r_state;
  logic [PW-1:0]                          r_wr_ptr;
  logic [PW-1:0]                          r_rd_ptr;
  logic [PW-1:0]                          r_frame_idx;
  logic [BW-1:0]                          r_beat;
  logic [CW-1:0]                          r_count;
  logic                                   r_overflow;
  logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] r_buf [OUT_NUM_OF_SET];

  logic                                   w_stream;
  logic                                   w_hs;
  logic                                   w_last;
  logic                                   w_pop;
  logic                                   w_full;
  logic                                   w_cap;
  logic                                   w_drop;
  logic [CW-1:0]                          w_count_nxt;
  logic [0:0]                             w_state_nxt;
  logic [EW-1:0]                          w_base;
  logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] w_entry;
  logic [LANES-1:0][DATA_WIDTH-1:0]       w_lanes;
  logic [LANES-1:0][DATA_WIDTH-1:0]       w_beat_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  // A final-beat pop frees its slot in the same cycle, so a full buffer can still accept.
  assign w_stream = (r_state == S_STREAM);
  assign w_hs     = w_stream & m_if.m_ready;
  assign w_last   = w_stream & (r_beat == LAST_BEAT);
  assign w_pop    = w_hs & (r_beat == LAST_BEAT);
  assign w_full   = (r_count == FULL_CNT);
  assign w_cap    = i_dout_valid & (~w_full | w_pop);
  assign w_drop   = i_dout_valid & w_full & ~w_pop;

  // Occupancy and state for the next cycle; IDLE looks at next count to hit one-cycle latency.
  always_comb begin
    w_count_nxt = r_count;
    w_state_nxt = r_state;
    if (w_cap && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_pop && !w_cap) begin
      w_count_nxt = r_count - CW'(1);
    end else begin
      w_count_nxt = r_count;
    end
    case (r_state)
      S_IDLE: begin
        if (w_count_nxt != {CW{1'b0}}) w_state_nxt = S_STREAM;
        else                           w_state_nxt = S_IDLE;
      end
      S_STREAM: begin
        if (w_pop && (w_count_nxt == {CW{1'b0}})) w_state_nxt = S_IDLE;
        else                                      w_state_nxt = S_STREAM;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Beat selection from the head entry, optional ReLU, forced to zero outside STREAM.
  always_comb begin
    w_base      = EW'(r_beat) * EW'(LANES);
    w_entry     = r_buf[r_rd_ptr];
    w_lanes     = w_entry[w_base +: LANES];
    w_beat_data = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef CONV_DRAIN_RELU_EN
      if (w_lanes[i][DATA_WIDTH-1]) w_beat_data[i] = '0;
      else                          w_beat_data[i] = w_lanes[i];
`else
      w_beat_data[i] = w_lanes[i];
`endif
    end
    if (w_stream) m_if.m_data = w_beat_data;
    else          m_if.m_data = '0;
  end

  // Control state: pointers, beat/frame counters, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_frame_idx <= '0;
      r_beat      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_cap) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop) begin
        r_rd_ptr    <= ptr_inc(r_rd_ptr);
        r_frame_idx <= ptr_inc(r_frame_idx);
        r_beat      <= '0;
      end else if (w_hs) begin
        r_beat <= r_beat + BW'(1);
      end
      if (w_drop)         r_overflow <= 1'b1;
      else if (i_ovf_clr) r_overflow <= 1'b0;
    end
  end

  // Set storage; contents need no reset, and a capture during reset is ignored.
  always_ff @(posedge clk) begin
    if (!rst && w_cap) r_buf[r_wr_ptr] <= i_dout;
  end

  assign m_if.m_valid      = w_stream;
  assign m_if.m_last       = w_last;
  assign m_if.m_frame_last = w_last & (r_frame_idx == LAST_PTR);
  assign o_level           = r_count;
  assign o_overflow        = r_overflow;

endmodule

// File: tb/tb_conv_out_drain.sv
// Self-checking bench for conv_out_drain: directed scenarios plus random traffic vs. a queue model.
module tb_conv_out_drain;
  localparam int DW    = 32;
  localparam int DOS   = 128;
  localparam int NSET  = 3;
  localparam int LN    = 4;
  localparam int BEATS = DOS / LN;
  localparam int CW    = $clog2(NSET + 1);

  typedef logic [DOS-1:0][DW-1:0] set_t;

  logic          clk = 1'b0;
  logic          rst;
  set_t          dout;
  logic          dout_valid;
  logic          ovf_clr;
  logic [CW-1:0] level;
  logic          overflow;

  conv_out_drain_if #(.DATA_WIDTH(DW), .LANES(LN)) m_if ();

  conv_out_drain #(
    .DATA_WIDTH(DW), .DATA_OF_SET(DOS), .OUT_NUM_OF_SET(NSET), .LANES(LN)
  ) dut (
    .clk(clk), .rst(rst), .i_dout(dout), .i_dout_valid(dout_valid),
    .m_if(m_if), .o_level(level), .o_overflow(overflow), .i_ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO of whole sets, position within head set, frame position, sticky flag.
  set_t q[$];
  int   mbeat;
  int   mframe;
  bit   movf;
  bit   chk_zero;
  int   n_vec;
  int   n_err;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [LN*DW-1:0] exp_beat(input set_t s, input int b);
    logic [DW-1:0] e;
    exp_beat = '0;
    for (int i = 0; i < LN; i++) begin
      e = s[b*LN+i];
`ifdef CONV_DRAIN_RELU_EN
      if ($signed(e) < 0) e = '0;
`endif
      exp_beat[i*DW +: DW] = e;
    end
  endfunction

  function automatic set_t const_set(input int v);
    set_t s;
    for (int i = 0; i < DOS; i++) s[i] = DW'(v);
    return s;
  endfunction

  function automatic set_t idx_set();
    set_t s;
    for (int i = 0; i < DOS; i++) s[i] = DW'(i);
    return s;
  endfunction

  function automatic set_t alt_set();
    set_t s;
    for (int i = 0; i < DOS; i++) s[i] = (i % 2 == 0) ? 32'd5 : 32'hFFFF_FFFB;
    return s;
  endfunction

  function automatic set_t rand_set();
    set_t s;
    for (int i = 0; i < DOS; i++) s[i] = $urandom();
    return s;
  endfunction

  task automatic check_outputs();
    bit v;
    bit l;
    v = (q.size() != 0);
    l = v && (mbeat == BEATS - 1);
    check_eq("m_valid", 256'(m_if.m_valid), 256'(v));
    check_eq("level", 256'(level), 256'(q.size()));
    check_eq("overflow", 256'(overflow), 256'(movf));
    check_eq("m_last", 256'(m_if.m_last), 256'(l));
    check_eq("m_frame_last", 256'(m_if.m_frame_last), 256'(l && (mframe == NSET - 1)));
    if (v) check_eq("m_data", 256'(m_if.m_data), 256'(exp_beat(q[0], mbeat)));
    else if (chk_zero) check_eq("m_data_rst", 256'(m_if.m_data), 256'(0));
  endtask

  task automatic model_step(input bit dv, input bit rdy, input bit clr, input bit r, input set_t d);
    bit drop;
    drop = 1'b0;
    if (r) begin
      q.delete();
      mbeat  = 0;
      mframe = 0;
      movf   = 1'b0;
    end else begin
      if (q.size() != 0 && rdy) begin
        if (mbeat == BEATS - 1) begin
          q.delete(0);
          mbeat  = 0;
          mframe = (mframe + 1) % NSET;
        end else begin
          mbeat++;
        end
      end
      if (dv) begin
        if (q.size() < NSET) q.push_back(d);
        else drop = 1'b1;
      end
      if (drop) movf = 1'b1;
      else if (clr) movf = 1'b0;
    end
    chk_zero = r;
  endtask

  // One clock: check what the last edge produced, then drive inputs for the next edge.
  task automatic cycle(input bit dv, input bit rdy, input bit clr, input bit r, input set_t d);
    @(negedge clk);
    check_outputs();
    dout_valid   = dv;
    m_if.m_ready = rdy;
    ovf_clr      = clr;
    rst          = r;
    dout         = d;
    model_step(dv, rdy, clr, r, d);
  endtask

  initial begin
    int dv_pct;
    bit rdv;
    n_vec = 0; n_err = 0;
    rst = 1'b1; dout_valid = 1'b0; ovf_clr = 1'b0; m_if.m_ready = 1'b0; dout = '0;
    mbeat = 0; mframe = 0; movf = 1'b0; chk_zero = 1'b1;
    repeat (2) @(posedge clk);

    // reset state, then a single constant set at full throughput
    cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, const_set(27));
    repeat (BEATS + 3) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // element ordering with m_ready toggling
    cycle(1'b1, 1'b1, 1'b0, 1'b0, idx_set());
    for (int k = 0; k < 2 * BEATS + 4; k++) cycle(1'b0, (k % 2) == 0, 1'b0, 1'b0, '0);

    // fill and overflow from a fresh frame, then clear and drain
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, const_set(k + 1));
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
    repeat (3 * BEATS + 3) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // full buffer: capture coincides with the final-beat pop
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, rand_set());
    for (int k = 0; k < BEATS - 1; k++) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, rand_set());
    repeat (3 * BEATS + 3) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // reset mid-stream at beat 10 with two sets held; capture in the reset cycle is ignored
    cycle(1'b1, 1'b1, 1'b0, 1'b0, rand_set());
    cycle(1'b1, 1'b1, 1'b0, 1'b0, rand_set());
    repeat (9) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, rand_set());
    cycle(1'b1, 1'b1, 1'b0, 1'b0, const_set(9));
    repeat (BEATS + 2) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // alternating +5 / -5 elements
    cycle(1'b1, 1'b1, 1'b0, 1'b0, alt_set());
    repeat (BEATS + 2) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // random traffic with varying capture density, backpressure, clears and rare resets
    dv_pct = 2;
    for (int k = 0; k < 3000; k++) begin
      if (k % 500 == 0) dv_pct = (k / 500 % 3 == 0) ? 2 : ((k / 500 % 3 == 1) ? 5 : 25);
      rdv = ($urandom_range(0, 99) < dv_pct);
      cycle(rdv, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
            $urandom_range(0, 699) == 0, rdv ? rand_set() : '0);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
